// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-organised data-memory slave for the core's load/store
//               stage. It latches a request, waits a programmable number of
//               cycles, commits the access and then pulses mem_ready for one
//               cycle. Misaligned accesses are suppressed and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_mem,
  input  logic                  write_enable_mem,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  mem_err
);

  localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] c_WAIT_CNT = 4'(WAIT_CYCLES);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_misaligned;
  logic                  r_is_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  logic                  w_request;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_unused_addr;

  // Address bits above the word index are deliberately ignored so that the
  // array aliases (wraps) across the full 32-bit byte address space.
  assign w_unused_addr = ^addr[31:ADDR_WIDTH+2];

  assign w_request = read_mem | write_enable_mem;
  assign w_accept  = (r_state == c_ST_IDLE) && w_request;
  assign w_commit  = (r_state == c_ST_BUSY) && (r_cnt == 4'd0);

  // State register; an asynchronous reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> BUSY on request, BUSY -> DONE at commit, DONE -> IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: if (w_request) w_next_state = c_ST_BUSY;
      c_ST_BUSY: if (r_cnt == 4'd0) w_next_state = c_ST_DONE;
      c_ST_DONE: w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  // Outputs decode the state register only, so nothing here depends on the request inputs.
  always_comb begin
    mem_ready = (r_state == c_ST_DONE);
    mem_busy  = (r_state != c_ST_IDLE);
    mem_err   = (r_state == c_ST_DONE) && r_err;
  end

  // Request capture and wait countdown; write wins when both requests are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 4'd0;
      r_idx        <= '0;
      r_misaligned <= 1'b0;
      r_is_write   <= 1'b0;
      r_wdata      <= '0;
    end else if (w_accept) begin
      r_cnt        <= c_WAIT_CNT;
      r_idx        <= addr[ADDR_WIDTH+1:2];
      r_misaligned <= |addr[1:0];
      r_is_write   <= write_enable_mem;
      r_wdata      <= wdata;
    end else if ((r_state == c_ST_BUSY) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Read data and error flag are updated only on the commit edge; a write leaves rdata alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err <= r_misaligned;
      if (!r_is_write) begin
        r_rdata <= r_misaligned ? '0 : r_mem[r_idx];
      end
    end
  end

  // Array write; contents survive reset, and a misaligned store is dropped.
  always_ff @(posedge clk) begin
    if (w_commit && r_is_write && !r_misaligned) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire
